// File: rtl/picorv32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_bus_arbiter
// Brief    : Two-master arbiter for the PicoRV32 native memory bus in front of
//            a TCM port. Master 0 is the core and master 1 is a loader/debug
//            bus. One master is granted per transaction, and the grant is held
//            until the slave completes. Arbitration takes one registered cycle.
//            After every transaction the arbiter passes through IDLE again.
// Config   : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests are
//            granted round-robin. Otherwise master 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module picorv32_bus_arbiter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    // master 0 (core)
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic [31:0]           m0_rdata,
    // master 1 (loader / debug)
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic [31:0]           m1_rdata,
    // slave (TCM)
    output logic                  s_valid,
    input  logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_wstrb,
    input  logic [31:0]           s_rdata
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   owner;
    logic   owner_next;
    logic   last_owner;
    logic   last_owner_next;
    logic   winner;
    logic   own_valid;

    // State, grant owner and round-robin history registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_owner <= last_owner_next;
        end
    end

    // Winner select: a lone requester always wins. On a tie, the fixed-priority
    // build masks the history bit to zero, so master 0 wins.
    always_comb begin
        winner = 1'b0;
        if (m0_valid && m1_valid) begin
            winner = RR_EN & ~last_owner;
        end else if (m1_valid) begin
            winner = 1'b1;
        end
    end

    // Next-state logic. Leave BUSY on completion, which updates history, or
    // when the owner withdraws its request, which does not update history.
    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_owner_next = last_owner;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    owner_next = winner;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!own_valid) begin
                    state_next = IDLE;
                end else if (s_ready) begin
                    state_next      = IDLE;
                    last_owner_next = owner;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slave-side mux follows the owner register. s_valid never depends on s_ready.
    always_comb begin
        own_valid = owner ? m1_valid : m0_valid;
        s_valid   = (state == BUSY) && own_valid;
        s_addr    = owner ? m1_addr  : m0_addr;
        s_wdata   = owner ? m1_wdata : m0_wdata;
        // Strobes are forced low while reset is held so that no write can leak out.
        s_wstrb   = reset_n ? (owner ? m1_wstrb : m0_wstrb) : 4'h0;
    end

    // Only the granted master sees the completion. Read data is shared.
    always_comb begin
        m0_ready = (state == BUSY) && !owner && s_ready;
        m1_ready = (state == BUSY) &&  owner && s_ready;
        m0_rdata = s_rdata;
        m1_rdata = s_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_picorv32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_picorv32_bus_arbiter
// Brief    : Self-checking bench for picorv32_bus_arbiter. It combines a table
//            of single transactions, a per-master scoreboard, contention runs,
//            protocol-violation sequences and a mid-transfer reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_picorv32_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [7:0]  m0_addr, m1_addr, s_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready;

    always #5 clock = ~clock;

    picorv32_bus_arbiter #(.ADDR_WIDTH(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata)
    );

    // TCM model: a write completes in the same cycle as s_valid, and a read
    // completes one cycle later. slave_hold stalls any completion.
    logic        slave_hold;
    logic        rd_wait;
    logic [31:0] mem [0:63];

    assign s_ready = !slave_hold && s_valid && ((s_wstrb != 4'h0) || rd_wait);
    assign s_rdata = mem[s_addr[7:2]];

    always @(posedge clock) begin
        if (!reset_n) begin
            rd_wait <= 1'b0;
            for (int i = 0; i < 64; i++) mem[i] <= (i == 8) ? 32'h12345678 : 32'h0;
        end else begin
            rd_wait <= s_valid && (s_wstrb == 4'h0) && !s_ready;
            if (s_valid && s_ready)
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   grant_log[$];
    int   done_cyc0[$];
    int   done_cyc1[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic retire(input bit mst);
        exp_t e;
        total++;
        if ((mst ? sb1.size() : sb0.size()) == 0) begin
            bad++;
            $display("FAIL m%0d_unexpected_ready: got ready=1 want no ready (t=%0t)", mst, $time);
            return;
        end
        total--;
        if (mst) e = sb1.pop_front(); else e = sb0.pop_front();
        check("retire_s_valid", 32'(s_valid), 32'd1);
        check("retire_s_addr",  32'(s_addr),  32'(e.addr));
        check("retire_s_wstrb", 32'(s_wstrb), 32'(e.wstrb));
        if (e.wstrb != 4'h0) check("retire_s_wdata", s_wdata, e.wdata);
        else check("retire_rdata", mst ? m1_rdata : m0_rdata, e.rdata);
        grant_log.push_back(int'(mst));
        if (mst) done_cyc1.push_back(cyc); else done_cyc0.push_back(cyc);
    endtask

    // Monitor: completions are popped from the scoreboard at the falling edge.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            check("ready_onehot", 32'(m0_ready & m1_ready), 32'd0);
            if (m0_ready) retire(1'b0);
            if (m1_ready) retire(1'b1);
        end
    end

    task automatic drive(input bit mst, input bit v, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (mst) begin
            m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
        end else begin
            m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
        end
    endtask

    // Called 1 ns after a rising edge. Returns 1 ns after the completing edge
    // with valid still asserted. lat is the number of rising edges to ready.
    task automatic run_txn(input bit mst, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat);
        bit done;
        done = 1'b0;
        drive(mst, 1'b1, a, d, s);
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            done = mst ? m1_ready : m0_ready;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL m%0d_txn_timeout: got no ready want ready", mst);
        end
        @(posedge clock); #1;
    endtask

    task automatic contention(input bit rd);
        int exp_order[8];
        int gap_same, gap_cross;
        grant_log.delete(); done_cyc0.delete(); done_cyc1.delete();
        fork
            begin
                int l0;
                for (int i = 0; i < 4; i++) begin
                    sb0.push_back('{8'(8'h40 + 4*i), 32'hA0000000 + i, rd ? 4'h0 : 4'hF,
                                    32'hA0000000 + i});
                    run_txn(1'b0, 8'(8'h40 + 4*i), 32'hA0000000 + i, rd ? 4'h0 : 4'hF, l0);
                end
                m0_valid = 1'b0;
            end
            begin
                int l1;
                for (int i = 0; i < 4; i++) begin
                    sb1.push_back('{8'(8'h80 + 4*i), 32'hB0000000 + i, rd ? 4'h0 : 4'hF,
                                    32'hB0000000 + i});
                    run_txn(1'b1, 8'(8'h80 + 4*i), 32'hB0000000 + i, rd ? 4'h0 : 4'hF, l1);
                end
                m1_valid = 1'b0;
            end
        join
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
        gap_same  = rd ? 6 : 4;
        gap_cross = rd ? 3 : 2;
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
        gap_same  = rd ? 3 : 2;
        gap_cross = rd ? 3 : 2;
`endif
        check("grant_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < grant_log.size()) check("grant_order", 32'(grant_log[k]), 32'(exp_order[k]));
        if (done_cyc0.size() == 4 && done_cyc1.size() == 4) begin
            for (int k = 1; k < 4; k++)
                check("m0_spacing", 32'(done_cyc0[k] - done_cyc0[k-1]), 32'(gap_same));
`ifdef ARB_ROUND_ROBIN_EN
            for (int k = 1; k < 4; k++)
                check("m1_spacing", 32'(done_cyc1[k] - done_cyc1[k-1]), 32'(gap_same));
`else
            check("m1_after_m0", 32'(done_cyc1[0] - done_cyc0[3]), 32'(gap_cross));
`endif
        end
        @(posedge clock); #1;
    endtask

    typedef struct {
        bit          mst;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vec[7];

    // Watchdog: stop the run if it exceeds its time budget.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        bit   first;
        bit   d0, d1;
        vec[0] = '{1'b0, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1};
        vec[1] = '{1'b1, 8'h20, 32'h0,        4'h0, 32'h12345678, 2};
        vec[2] = '{1'b1, 8'h24, 32'hCAFEF00D, 4'h3, 32'h0,        1};
        vec[3] = '{1'b0, 8'h24, 32'h0,        4'h0, 32'h0000F00D, 2};
        vec[4] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, 2};
        vec[5] = '{1'b1, 8'h10, 32'h11223344, 4'hC, 32'h0,        1};
        vec[6] = '{1'b1, 8'h10, 32'h0,        4'h0, 32'h1122BEEF, 2};

        // Reset state, with both masters requesting so the checks discriminate.
        reset_n = 1'b0; slave_hold = 1'b0;
        drive(1'b0, 1'b1, 8'h5A, 32'h5A5A5A5A, 4'hF);
        drive(1'b1, 1'b1, 8'hA5, 32'hA5A5A5A5, 4'hF);
        #2;
        check("rst_s_valid",  32'(s_valid),  32'd0);
        check("rst_m0_ready", 32'(m0_ready), 32'd0);
        check("rst_m1_ready", 32'(m1_ready), 32'd0);
        check("rst_s_wstrb",  32'(s_wstrb),  32'd0);
        check("rst_s_addr",   32'(s_addr),   32'h5A);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_hold_s_valid", 32'(s_valid), 32'd0);
        drive(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 8'h0, 32'h0, 4'h0);
        @(posedge clock); #1; reset_n = 1'b1;
        @(posedge clock); #1;

        // Single transactions from the table.
        for (int i = 0; i < 7; i++) begin
            if (vec[i].mst) sb1.push_back('{vec[i].addr, vec[i].wdata, vec[i].wstrb, vec[i].rdata});
            else            sb0.push_back('{vec[i].addr, vec[i].wdata, vec[i].wstrb, vec[i].rdata});
            run_txn(vec[i].mst, vec[i].addr, vec[i].wdata, vec[i].wstrb, lat);
            check("vec_latency", 32'(lat), 32'(vec[i].lat));
            drive(vec[i].mst, 1'b0, 8'h0, 32'h0, 4'h0);
            @(negedge clock);
            check("vec_idle_after", 32'(s_valid), 32'd0);
            @(posedge clock); #1;
        end

        // Continuous requests from both masters: writes, then reads back.
        contention(1'b0);
        contention(1'b1);

        // m0 withdraws its request while granted, and pending m1 takes over.
        slave_hold = 1'b1;
        sb1.push_back('{8'h60, 32'h60606060, 4'hF, 32'h0});
        drive(1'b0, 1'b1, 8'h50, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 8'h60, 32'h60606060, 4'hF);
        @(posedge clock); @(negedge clock);
        check("viol_grant_valid", 32'(s_valid), 32'd1);
        check("viol_grant_addr",  32'(s_addr),  32'h50);
        @(posedge clock); #1; m0_valid = 1'b0;
        @(posedge clock); @(negedge clock);
        check("viol_idle", 32'(s_valid), 32'd0);
        @(posedge clock); #1; slave_hold = 1'b0;
        @(negedge clock);
        check("viol_m1_valid", 32'(s_valid), 32'd1);
        check("viol_m1_addr",  32'(s_addr),  32'h60);
        @(posedge clock); #1; m1_valid = 1'b0;

        // A withdrawn m1 grant leaves the history bit untouched, so the next
        // tie goes to m1 under round-robin and to m0 under fixed priority.
        sb0.push_back('{8'h54, 32'h54545454, 4'hF, 32'h0});
        run_txn(1'b0, 8'h54, 32'h54545454, 4'hF, lat);
        m0_valid = 1'b0;
        slave_hold = 1'b1;
        drive(1'b1, 1'b1, 8'h64, 32'h0, 4'h0);
        @(posedge clock); @(negedge clock);
        check("viol2_grant_addr", 32'(s_addr), 32'h64);
        @(posedge clock); #1; m1_valid = 1'b0;
        @(posedge clock); #1; slave_hold = 1'b0;
        sb0.push_back('{8'h68, 32'h68686868, 4'hF, 32'h0});
        sb1.push_back('{8'h6C, 32'h6C6C6C6C, 4'hF, 32'h0});
        drive(1'b0, 1'b1, 8'h68, 32'h68686868, 4'hF);
        drive(1'b1, 1'b1, 8'h6C, 32'h6C6C6C6C, 4'hF);
        first = 1'b1;
        d0 = 1'b0; d1 = 1'b0;
        for (int k = 0; k < 12 && !(d0 && d1); k++) begin
            @(negedge clock);
            if (first && s_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                check("tie_after_viol", 32'(s_addr), 32'h6C);
`else
                check("tie_after_viol", 32'(s_addr), 32'h68);
`endif
                first = 1'b0;
            end
            if (m0_ready) d0 = 1'b1;
            if (m1_ready) d1 = 1'b1;
            @(posedge clock); #1;
            if (d0) m0_valid = 1'b0;
            if (d1) m1_valid = 1'b0;
        end
        check("tie_both_done", 32'({d0, d1}), 32'd3);

        // Reset in the middle of a stalled m0 write aborts it. m0 is then
        // re-granted one cycle after reset is released.
        slave_hold = 1'b1;
        drive(1'b0, 1'b1, 8'h70, 32'h5555AAAA, 4'hF);
        @(posedge clock); @(negedge clock);
        check("mrst_busy", 32'(s_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mrst_s_valid",  32'(s_valid),  32'd0);
        check("mrst_m0_ready", 32'(m0_ready), 32'd0);
        check("mrst_s_wstrb",  32'(s_wstrb),  32'd0);
        check("mrst_s_addr",   32'(s_addr),   32'h70);
        slave_hold = 1'b0;
        @(posedge clock); #1; reset_n = 1'b1;
        sb0.push_back('{8'h70, 32'h5555AAAA, 4'hF, 32'h0});
        @(negedge clock);
        check("mrst_idle", 32'(s_valid), 32'd0);
        @(posedge clock); @(negedge clock);
        check("mrst_regrant",  32'(s_valid),  32'd1);
        check("mrst_m0_ready", 32'(m0_ready), 32'd1);
        @(posedge clock); #1; m0_valid = 1'b0;
        repeat (2) @(posedge clock);

        check("sb0_empty", 32'(sb0.size()), 32'd0);
        check("sb1_empty", 32'(sb1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/picorv32_bus_arbiter.md
# picorv32_bus_arbiter

Two-master arbiter for the PicoRV32 native memory bus, sitting directly upstream of the tightly-coupled memory (TCM) port. It merges the core's bus (master 0) and a loader/debug bus (master 1) onto one slave port. It grants one master per transaction and holds the grant until the slave completes the transfer. Slave-side signals are passed through combinationally once granted; arbitration costs one registered cycle.

## Interface
- ADDR_WIDTH, 8, byte-address width on all ports.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_valid / m1_valid  in  1  master request, held until that master's ready.
- m0_ready / m1_ready  out  1  transfer complete for that master.
- m0_addr / m1_addr  in  ADDR_WIDTH  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte enables; 0 = read.
- m0_rdata / m1_rdata  out  32  read data; both driven from s_rdata.
- s_valid  out  1  request to slave.
- s_ready  in  1  slave completion.
- s_addr  out  ADDR_WIDTH  granted master's address.
- s_wdata  out  32  granted master's write data.
- s_wstrb  out  4  granted master's byte enables.
- s_rdata  in  32  slave read data.

## Operation
- State machine: IDLE, BUSY. A registered `owner` bit (0/1) and a `last_owner` bit (round-robin history) accompany it.
- IDLE:
  - s_valid=0 and m*_ready=0.
  - s_addr/s_wdata/s_wstrb mux to the `owner` register value.
  - If any m*_valid=1: pick a winner, load `owner`, go to BUSY.
- BUSY:
  - s_valid = m[owner]_valid; s_addr/s_wdata/s_wstrb = m[owner] fields.
  - m[owner]_ready = s_ready; the other master's ready = 0.
- Completion: s_valid && s_ready in BUSY → next state IDLE, last_owner ← owner.
- Protocol violation: m[owner]_valid drops in BUSY without ready → next state IDLE. No last_owner update.
- Non-granted master:
  - Its request stays pending and is never lost.
  - It is served by the next arbitration after the current transaction ends.
- Winner selection with a single requester: that requester.
- Winner selection with both requesting: see Configuration.
- Reset (async, reset_n=0):
  - state=IDLE, owner=0, last_owner=1.
  - Outputs immediately: s_valid=0, m0_ready=0, m1_ready=0, s_wstrb=0, s_addr=m0_addr.
  - Reset mid-transaction aborts the transfer; no ready is issued to the master.

## Timing
- Arbitration latency: request seen in IDLE at edge N → s_valid=1 from cycle N+1.
- Added latency per transaction: 1 cycle, plus 1 idle cycle after every completion (IDLE is always re-entered).
- Back-to-back throughput, single-cycle slave: one transaction per 2 cycles.
- Write to a TCM without look-ahead: ready in the same cycle as s_valid. Master sees ready at N+1.
- Read from a TCM without look-ahead: ready one cycle after s_valid. Master sees ready at N+2; rdata is valid in that cycle.
- Owner's valid falls the cycle after ready. The arbiter is already in IDLE then, so no spurious re-grant occurs.
- The arbiter creates no combinational path from s_ready to s_valid.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant goes to the master ≠ last_owner. After reset, master 0 wins first because last_owner=1.
- ARB_ROUND_ROBIN_EN undefined: fixed priority; master 0 always wins simultaneous requests. last_owner is still maintained but ignored.

## Test plan
- Reset: assert reset_n=0 mid-BUSY with m0 writing → s_valid and m0_ready fall within the same cycle. After release, state is IDLE and m0 is re-granted one cycle later.
- Single write: m0 writes addr 0x10, data 0xDEADBEEF, wstrb 0xF, to a write-ready-immediate slave → s_valid at N+1, m0_ready=1 at N+1, m1_ready=0 throughout.
- Single read: m1 reads 0x20, slave returns 0x12345678 at N+2 → m1_rdata=0x12345678 with m1_ready=1 at N+2, then s_valid=0.
- Contention, macro defined: m0 and m1 request continuously → grants alternate 0,1,0,1 and each master completes every 4 cycles (write) / 6 cycles (read).
- Contention, macro undefined: m0 requests continuously while m1 also requests → m1 is never granted while m0 re-requests in IDLE. m1 is granted the cycle after m0 idles.
- Violation: m0 granted, drops valid before s_ready → next cycle IDLE, pending m1 granted the cycle after, last_owner unchanged.
